// File: rtl/avalon_mm_master_bridge_pkg.sv
// ---------------------------------------------------------------------------
// avalon_mm_master_bridge_pkg
// Shared types for the Avalon-MM master bridge and its register slaves:
//   state_t          - bridge FSM states (IDLE / XFER / RESP)
//   cmd_t            - queued local command {write, address, writedata}
//   CMD_W            - packed width of cmd_t (49 bits)
//   ERR_DATA_DEFAULT - readback word used for aborted transfers; slaves use
//                      the same value as their default readback
// ---------------------------------------------------------------------------
package avalon_mm_master_bridge_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_XFER = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   typedef struct packed {
      logic        write;
      logic [15:0] address;
      logic [31:0] writedata;
   } cmd_t;

   localparam int CMD_W = $bits(cmd_t);

   localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

endpackage

// File: rtl/avalon_mm_master_bridge_cmd_fifo.sv
// ---------------------------------------------------------------------------
// avalon_mm_master_bridge_cmd_fifo
// Synchronous FIFO holding pending commands. Push and pop may happen in the
// same cycle; both take effect and the count is unchanged. Pushes while full
// and pops while empty are ignored.
// Ports:
//   clock, reset      clock, async active-high reset (empties the FIFO)
//   push, push_data   write side
//   pop, pop_data     read side; pop_data shows the head entry (show-ahead)
//   full, empty       status flags
//   count             number of stored entries
// ---------------------------------------------------------------------------
module avalon_mm_master_bridge_cmd_fifo #(
   parameter int WIDTH = 49,
   parameter int DEPTH = 4
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           pop_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full     = (count == (AW+1)'(DEPTH));
   assign empty    = (count == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   // Storage is not reset: entries are only visible through count.
   always_ff @(posedge clock) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // DEPTH is a power of two, so the pointers wrap on their own.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

endmodule

// File: rtl/avalon_mm_master_bridge.sv
// ---------------------------------------------------------------------------
// avalon_mm_master_bridge
// Avalon-MM initiator. Local register commands are queued in a FIFO and
// issued one at a time as Avalon-MM master transfers; each command returns
// exactly one response, in command order.
// Ports:
//   clock, reset                  clock, async active-high reset
//   cmd_valid/cmd_ready           command handshake (see below)
//   cmd_write/cmd_address/cmd_writedata   command payload
//   rsp_valid                     one-cycle pulse per completed command
//   rsp_readdata/rsp_error        read result (0 for writes, ERR_DATA on
//                                 timeout) and timeout flag
//   busy                          FIFO non-empty or transfer in flight
//   avalon_master_*               Avalon-MM master port
//
// Handshake: a command transfers on a rising clock edge where cmd_valid and
// cmd_ready are both high. While cmd_valid is high and cmd_ready is low the
// source holds the command unchanged. There is no response back-pressure:
// rsp_valid is a single-cycle pulse the consumer must take.
// ---------------------------------------------------------------------------
module avalon_mm_master_bridge
   import avalon_mm_master_bridge_pkg::*;
#(
   parameter int          FIFO_DEPTH     = 4,
   parameter int          TIMEOUT_CYCLES = 255,
   parameter logic [31:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [15:0] cmd_address,
   input  logic [31:0] cmd_writedata,
   output logic        rsp_valid,
   output logic [31:0] rsp_readdata,
   output logic        rsp_error,
   output logic        busy,
   output logic [15:0] avalon_master_address,
   output logic        avalon_master_write,
   output logic [31:0] avalon_master_writedata,
   output logic        avalon_master_read,
   input  logic [31:0] avalon_master_readdata,
   input  logic        avalon_master_waitrequest
);

   localparam int                CNT_W      = $clog2(TIMEOUT_CYCLES + 1);
   // Value of the stall counter on the last allowed waitrequest cycle.
   localparam logic [CNT_W-1:0]  STALL_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t                        state;
   state_t                        state_nxt;
   cmd_t                          push_cmd;
   cmd_t                          head_cmd;
   logic                          fifo_full;
   logic                          fifo_empty;
   logic [$clog2(FIFO_DEPTH):0]   fifo_count;
   logic                          pop_cmd;
   logic                          xfer_done;
   logic                          xfer_timeout;
   logic [CNT_W-1:0]              stall_cnt;

   assign push_cmd  = '{write: cmd_write, address: cmd_address, writedata: cmd_writedata};
   assign cmd_ready = !fifo_full && !reset;
   assign busy      = (fifo_count != '0) || (state != ST_IDLE);
   assign rsp_valid = (state == ST_RESP);

   avalon_mm_master_bridge_cmd_fifo #(
      .WIDTH (CMD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_cmd_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (cmd_valid && cmd_ready),
      .push_data (push_cmd),
      .pop       (pop_cmd),
      .pop_data  (head_cmd),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      pop_cmd      = 1'b0;
      xfer_done    = 1'b0;
      xfer_timeout = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!fifo_empty) begin
               pop_cmd   = 1'b1;
               state_nxt = ST_XFER;
            end
         end
         ST_XFER: begin
            if (!avalon_master_waitrequest) begin
               xfer_done = 1'b1;
               state_nxt = ST_RESP;
            end else if (stall_cnt == STALL_LAST) begin
               xfer_timeout = 1'b1;
               state_nxt    = ST_RESP;
            end
         end
         ST_RESP: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Bus strobes, address and data are registered: they rise the cycle after
   // the pop and stay frozen until the transfer ends. RESP always sits between
   // two transfers, so the strobes are low for at least one cycle.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         avalon_master_address   <= '0;
         avalon_master_writedata <= '0;
         avalon_master_write     <= 1'b0;
         avalon_master_read      <= 1'b0;
         stall_cnt               <= '0;
         rsp_readdata            <= '0;
         rsp_error               <= 1'b0;
      end else begin
         if (pop_cmd) begin
            avalon_master_address   <= head_cmd.address;
            avalon_master_writedata <= head_cmd.writedata;
            avalon_master_write     <= head_cmd.write;
            avalon_master_read      <= !head_cmd.write;
            stall_cnt               <= '0;
         end
         if (xfer_done) begin
            avalon_master_write <= 1'b0;
            avalon_master_read  <= 1'b0;
            rsp_readdata        <= avalon_master_read ? avalon_master_readdata : '0;
            rsp_error           <= 1'b0;
         end else if (xfer_timeout) begin
            avalon_master_write <= 1'b0;
            avalon_master_read  <= 1'b0;
            rsp_readdata        <= ERR_DATA;
            rsp_error           <= 1'b1;
         end else if (state == ST_XFER) begin
            // Cannot wrap: the timeout fires before the counter saturates.
            stall_cnt <= stall_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_avalon_mm_master_bridge.sv
module tb_avalon_mm_master_bridge;
   import avalon_mm_master_bridge_pkg::*;

   localparam int TIMEOUT = 8;

   // ---------------- clock / reset ----------------
   logic        clock = 1'b0;
   logic        reset = 1'b0;
   always #5 clock = ~clock;

   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_write = 1'b0;
   logic [15:0] cmd_address = '0;
   logic [31:0] cmd_writedata = '0;
   logic        rsp_valid;
   logic [31:0] rsp_readdata;
   logic        rsp_error;
   logic        busy;
   logic [15:0] avalon_master_address;
   logic        avalon_master_write;
   logic [31:0] avalon_master_writedata;
   logic        avalon_master_read;
   logic [31:0] avalon_master_readdata;
   logic        avalon_master_waitrequest;

   avalon_mm_master_bridge #(
      .FIFO_DEPTH     (4),
      .TIMEOUT_CYCLES (TIMEOUT),
      .ERR_DATA       (32'hDEADBEEF)
   ) dut (
      .clock                     (clock),
      .reset                     (reset),
      .cmd_valid                 (cmd_valid),
      .cmd_ready                 (cmd_ready),
      .cmd_write                 (cmd_write),
      .cmd_address               (cmd_address),
      .cmd_writedata             (cmd_writedata),
      .rsp_valid                 (rsp_valid),
      .rsp_readdata              (rsp_readdata),
      .rsp_error                 (rsp_error),
      .busy                      (busy),
      .avalon_master_address     (avalon_master_address),
      .avalon_master_write       (avalon_master_write),
      .avalon_master_writedata   (avalon_master_writedata),
      .avalon_master_read        (avalon_master_read),
      .avalon_master_readdata    (avalon_master_readdata),
      .avalon_master_waitrequest (avalon_master_waitrequest)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // ---------------- slave model ----------------
   int          wait_cfg      = 0;
   bit          stuck         = 1'b0;
   bit          rand_wait     = 1'b0;
   int          rand_wait_val = 0;
   int          wcnt;
   logic [31:0] slave_mem     [4096];
   bit          slave_written [4096];
   logic        strobe;
   logic [11:0] idx;
   int          eff_wait;

   function automatic logic [31:0] init_val(input logic [15:0] a);
      if (a == 16'h0100) return 32'h12345678;
      return {a, ~a};
   endfunction

   assign strobe   = avalon_master_read | avalon_master_write;
   assign idx      = avalon_master_address[11:0];
   assign eff_wait = rand_wait ? rand_wait_val : wait_cfg;
   assign avalon_master_waitrequest = strobe && (stuck || (wcnt < eff_wait));
   assign avalon_master_readdata    = slave_written[idx] ? slave_mem[idx] : init_val(avalon_master_address);

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         wcnt <= 0;
      end else if (!strobe) begin
         wcnt <= 0;
      end else if (avalon_master_waitrequest) begin
         wcnt <= wcnt + 1;
      end else begin
         wcnt <= 0;
         rand_wait_val <= $urandom_range(0, 3);
         if (avalon_master_write) begin
            slave_mem[idx]     <= avalon_master_writedata;
            slave_written[idx] <= 1'b1;
         end
      end
   end

   // ---------------- scoreboard ----------------
   logic [31:0] exp_q[$];
   logic        exp_err_q[$];
   logic [31:0] shadow_mem     [4096];
   bit          shadow_written [4096];
   int          rsp_count = 0;

   always @(negedge clock) begin
      logic [31:0] e;
      logic        ee;
      if (!reset && rsp_valid) begin
         rsp_count++;
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL unexpected_rsp: observed=0x%08h expected=no response", rsp_readdata);
         end else begin
            e  = exp_q.pop_front();
            ee = exp_err_q.pop_front();
            check("rsp_readdata", rsp_readdata, e);
            check("rsp_error", {31'b0, rsp_error}, {31'b0, ee});
         end
      end
   end

   // ---------------- bus protocol monitors ----------------
   logic        prev_hold = 1'b0;
   logic [49:0] prev_bus;
   int          rd_run = 0, wr_run = 0, last_rd_len = 0, last_wr_len = 0;

   always @(negedge clock) begin
      if (reset) begin
         prev_hold = 1'b0;
         rd_run    = 0;
         wr_run    = 0;
      end else begin
         // Strobes may only drop (timeout abort) after a stalled cycle; if
         // still asserted, everything must be unchanged.
         if (prev_hold && strobe) begin
            assert ({avalon_master_read, avalon_master_write, avalon_master_address,
                     avalon_master_writedata} === prev_bus) else begin
               bad++;
               $error("FAIL bus_stable: observed=0x%013h expected=0x%013h",
                      {avalon_master_read, avalon_master_write, avalon_master_address,
                       avalon_master_writedata}, prev_bus);
            end
         end
         assert (!(avalon_master_read && avalon_master_write)) else begin
            bad++;
            $error("FAIL read_and_write: observed=1 expected=0");
         end
         prev_hold = strobe && avalon_master_waitrequest;
         prev_bus  = {avalon_master_read, avalon_master_write, avalon_master_address,
                      avalon_master_writedata};
         if (avalon_master_read) rd_run++;
         else if (rd_run != 0) begin last_rd_len = rd_run; rd_run = 0; end
         if (avalon_master_write) wr_run++;
         else if (wr_run != 0) begin last_wr_len = wr_run; wr_run = 0; end
      end
   end

   // ---------------- driver tasks ----------------
   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic send(input logic w, input logic [15:0] a, input logic [31:0] d,
                       input bit exp_timeout);
      int n = 0;
      cmd_valid     = 1'b1;
      cmd_write     = w;
      cmd_address   = a;
      cmd_writedata = d;
      while (!cmd_ready && n < 500) begin
         @(negedge clock);
         n++;
      end
      if (!cmd_ready) begin
         total++;
         bad++;
         $error("FAIL cmd_accept_timeout: observed=cmd_ready 0 expected=cmd_ready 1");
         cmd_valid = 1'b0;
         return;
      end
      if (exp_timeout) begin
         exp_q.push_back(32'hDEADBEEF);
         exp_err_q.push_back(1'b1);
      end else if (w) begin
         shadow_mem[a[11:0]]     = d;
         shadow_written[a[11:0]] = 1'b1;
         exp_q.push_back(32'h0);
         exp_err_q.push_back(1'b0);
      end else begin
         exp_q.push_back(shadow_written[a[11:0]] ? shadow_mem[a[11:0]] : init_val(a));
         exp_err_q.push_back(1'b0);
      end
      @(negedge clock);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 2000) begin
         @(negedge clock);
         n++;
      end
      total++;
      if (busy) begin
         bad++;
         $error("FAIL idle_timeout: observed=busy 1 expected=busy 0");
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: observed=no finish expected=finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- directed + random stimulus ----------------
   initial begin
      int base;
      logic        w;
      logic [15:0] a;

      #1 reset = 1'b1;
      repeat (3) @(negedge clock);
      check("rst_busy", {31'b0, busy}, 32'h0);
      check("rst_read", {31'b0, avalon_master_read}, 32'h0);
      check("rst_write", {31'b0, avalon_master_write}, 32'h0);
      check("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
      check("rst_address", {16'b0, avalon_master_address}, 32'h0);
      reset = 1'b0;
      @(negedge clock);
      check("rel_cmd_ready", {31'b0, cmd_ready}, 32'h1);

      // Single read, one wait cycle.
      wait_cfg = 1;
      send(1'b0, 16'h0100, 32'h0, 1'b0);
      check("t1_read_n1", {31'b0, avalon_master_read}, 32'h0);
      check("t1_busy", {31'b0, busy}, 32'h1);
      @(negedge clock);
      check("t1_read_n2", {31'b0, avalon_master_read}, 32'h1);
      check("t1_addr", {16'b0, avalon_master_address}, 32'h0000_0100);
      @(negedge clock);
      check("t1_read_n3", {31'b0, avalon_master_read}, 32'h1);
      @(negedge clock);
      check("t1_read_drop", {31'b0, avalon_master_read}, 32'h0);
      check("t1_rsp_valid", {31'b0, rsp_valid}, 32'h1);
      wait_idle();
      check("t1_read_len", last_rd_len, 2);
      check("t1_rsp_count", rsp_count, 1);

      // Write, three wait cycles.
      wait_cfg = 3;
      send(1'b1, 16'h0200, 32'hFFFF_FFFF, 1'b0);
      wait_idle();
      check("t2_write_len", last_wr_len, 4);
      check("t2_rsp_count", rsp_count, 2);

      // Zero-wait read: minimum latency.
      wait_cfg = 0;
      send(1'b0, 16'h0200, 32'h0, 1'b0);
      @(negedge clock);
      check("t2b_read", {31'b0, avalon_master_read}, 32'h1);
      @(negedge clock);
      check("t2b_rsp_valid", {31'b0, rsp_valid}, 32'h1);
      wait_idle();

      // Five back-to-back commands against a slow slave fill the FIFO.
      wait_cfg = 6;
      base = rsp_count;
      send(1'b1, 16'h0400, 32'hAAAA_0001, 1'b0);
      send(1'b0, 16'h0400, 32'h0, 1'b0);
      send(1'b1, 16'h0401, 32'h8000_0002, 1'b0);
      send(1'b0, 16'h0200, 32'h0, 1'b0);
      send(1'b0, 16'h0401, 32'h0, 1'b0);
      check("t3_cmd_ready_full", {31'b0, cmd_ready}, 32'h0);
      wait_idle();
      check("t3_rsp_count", rsp_count - base, 5);
      check("t3_cmd_ready_after", {31'b0, cmd_ready}, 32'h1);

      // Stuck slave: timeout, then normal operation resumes.
      stuck = 1'b1;
      send(1'b0, 16'h0300, 32'h0, 1'b1);
      wait_idle();
      check("t4_read_len", last_rd_len, TIMEOUT);
      stuck    = 1'b0;
      wait_cfg = 1;
      send(1'b1, 16'h0300, 32'h55AA_55AA, 1'b0);
      send(1'b0, 16'h0300, 32'h0, 1'b0);
      wait_idle();
      check("t4_write_len", last_wr_len, 2);
      check("t4_read_len2", last_rd_len, 2);

      // Reset during a stalled transfer with two commands queued.
      stuck = 1'b1;
      send(1'b0, 16'h0100, 32'h0, 1'b0);
      send(1'b0, 16'h0200, 32'h0, 1'b0);
      send(1'b0, 16'h0300, 32'h0, 1'b0);
      @(negedge clock);
      check("t5_inflight", {31'b0, avalon_master_read}, 32'h1);
      exp_q.delete();
      exp_err_q.delete();
      base = rsp_count;
      #2 reset = 1'b1;
      #1;
      check("t5_rst_read", {31'b0, avalon_master_read}, 32'h0);
      check("t5_rst_write", {31'b0, avalon_master_write}, 32'h0);
      check("t5_rst_busy", {31'b0, busy}, 32'h0);
      check("t5_rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
      stuck = 1'b0;
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      check("t5_cmd_ready", {31'b0, cmd_ready}, 32'h1);
      repeat (10) @(negedge clock);
      check("t5_no_rsp", rsp_count - base, 0);
      check("t5_busy", {31'b0, busy}, 32'h0);

      // Random commands against a random-wait slave.
      rand_wait = 1'b1;
      base = rsp_count;
      for (int i = 0; i < 40; i++) begin
         w = 1'($urandom_range(0, 1));
         a = 16'h0400 + 16'($urandom_range(0, 7));
         send(w, a, $urandom, 1'b0);
         repeat ($urandom_range(0, 2)) @(negedge clock);
      end
      wait_idle();
      repeat (2) @(negedge clock);
      check("t6_rsp_count", rsp_count - base, 40);
      check("queue_drained", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
